// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives the PC absolute-jump port for start, halt, stall, branch, call and return.
// Optional return-address stack enabled by defining PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
  parameter int D  = 12,
  parameter int L  = 4,
  parameter int RD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         halt_req,
  input  logic         stall,
  input  logic         br_valid,
  input  logic         br_taken,
  input  logic         call_valid,
  input  logic         ret_valid,
  input  logic [L-1:0] lut_idx,
  input  logic         cfg_we,
  input  logic [L-1:0] cfg_addr,
  input  logic [D-1:0] cfg_data,
  input  logic [D-1:0] prog_ctr,
  output logic         absjump_en,
  output logic [D-1:0] target,
  output logic         running,
  output logic         done,
  output logic         ras_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_HOLD,
    ACT_POP,
    ACT_POP_EMPTY,
    ACT_CALL,
    ACT_JUMP
  } act_t;

  state_t         state;
  state_t         next_state;
  act_t           act;
  logic [D-1:0]   pc_inc;
  logic [D-1:0]   lut_data;
  logic [D-1:0]   ras_top;
  logic           ras_empty;
  logic [D-1:0]   lut [2**L];

  assign pc_inc   = prog_ctr + D'(1);
  assign lut_data = lut[lut_idx];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
      done    <= (next_state == HALT);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start)    next_state = RUN;
      RUN:     if (halt_req) next_state = HALT;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // Resolve the single winning request in RUN; lower-priority requests are dropped.
  always_comb begin
    act = ACT_NONE;
    if (state == RUN) begin
      if (halt_req || stall)
        act = ACT_HOLD;
`ifdef PC_SEQUENCER_RAS_EN
      else if (ret_valid)
        act = ras_empty ? ACT_POP_EMPTY : ACT_POP;
`endif
      else if (call_valid)
        act = ACT_CALL;
      else if (br_valid && br_taken)
        act = ACT_JUMP;
    end
  end

  // Halt and stall are a jump-to-self; target tracks pc+1 when no jump so it stays deterministic.
  always_comb begin
    absjump_en = 1'b0;
    target     = pc_inc;
    unique case (state)
      IDLE: begin
        absjump_en = 1'b1;
        target     = '0;
      end
      RUN: begin
        unique case (act)
          ACT_HOLD: begin
            absjump_en = 1'b1;
            target     = prog_ctr;
          end
          ACT_POP: begin
            absjump_en = 1'b1;
            target     = ras_top;
          end
          ACT_CALL, ACT_JUMP: begin
            absjump_en = 1'b1;
            target     = lut_data;
          end
          default: begin
            absjump_en = 1'b0;
            target     = pc_inc;
          end
        endcase
      end
      HALT: begin
        absjump_en = 1'b1;
        target     = prog_ctr;
      end
      default: begin
        absjump_en = 1'b1;
        target     = '0;
      end
    endcase
  end

  // NOTE: storage arrays are deliberately not reset; only control state needs a known value.
  always_ff @(posedge clk) begin
    if (state == IDLE && cfg_we)
      lut[cfg_addr] <= cfg_data;
  end

`ifdef PC_SEQUENCER_RAS_EN
  localparam int PW = (RD > 1) ? $clog2(RD) : 1;
  localparam int CW = $clog2(RD + 1);

  logic [D-1:0]  ras [RD];
  logic [PW-1:0] ras_ptr;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;
  logic [CW-1:0] ras_cnt;
  logic          ras_full;

  // ras_ptr is the next free slot; a full push wraps over the oldest entry.
  assign ptr_inc   = (ras_ptr == PW'(RD - 1)) ? '0 : ras_ptr + PW'(1);
  assign ptr_dec   = (ras_ptr == '0) ? PW'(RD - 1) : ras_ptr - PW'(1);
  assign ras_top   = ras[ptr_dec];
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CW'(RD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      ras_err <= 1'b0;
    end else begin
      unique case (act)
        ACT_CALL: begin
          ras_ptr <= ptr_inc;
          if (ras_full) ras_err <= 1'b1;
          else          ras_cnt <= ras_cnt + CW'(1);
        end
        ACT_POP: begin
          ras_ptr <= ptr_dec;
          ras_cnt <= ras_cnt - CW'(1);
        end
        ACT_POP_EMPTY: ras_err <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (act == ACT_CALL)
      ras[ras_ptr] <= pc_inc;
  end
`else
  localparam int unused_rd = RD;
  logic unused_ret;

  assign unused_ret = ret_valid;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural PC closes the loop, expected values are hand-derived.
// Expectations for call/return adapt to whether PC_SEQUENCER_RAS_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        call_valid = 1'b0;
  logic        ret_valid = 1'b0;
  logic [3:0]  lut_idx = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [11:0] cfg_data = '0;
  logic [11:0] prog_ctr;
  logic        absjump_en;
  logic [11:0] target;
  logic        running;
  logic        done;
  logic        ras_err;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.D(12), .L(4), .RD(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt_req   (halt_req),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .call_valid (call_valid),
    .ret_valid  (ret_valid),
    .lut_idx    (lut_idx),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .prog_ctr   (prog_ctr),
    .absjump_en (absjump_en),
    .target     (target),
    .running    (running),
    .done       (done),
    .ras_err    (ras_err)
  );

  always #5 clk = ~clk;

  // The program counter the sequencer steers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           prog_ctr <= '0;
    else if (absjump_en) prog_ctr <= target;
    else                 prog_ctr <= prog_ctr + 12'd1;
  end

`ifdef PC_SEQUENCER_RAS_EN
  localparam logic [11:0] EXP_RET1     = 12'h021;
  localparam logic        EXP_OVF_ERR  = 1'b1;
  localparam logic [11:0] EXP_RETS [5] = '{12'h011, 12'h124, 12'h301, 12'h201, 12'h202};
  localparam logic [11:0] EXP_COMBO    = 12'h203;
`else
  localparam logic [11:0] EXP_RET1     = 12'h203;
  localparam logic        EXP_OVF_ERR  = 1'b0;
  localparam logic [11:0] EXP_RETS [5] = '{12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4, 12'h0A5};
  localparam logic [11:0] EXP_COMBO    = 12'h200;
`endif

  localparam logic [3:0]  CALL_IDX [5] = '{4'd1, 4'd4, 4'd5, 4'd6, 4'd3};
  localparam logic [11:0] CALL_PC  [5] = '{12'h200, 12'h300, 12'h123, 12'h010, 12'h0A0};
  localparam logic [3:0]  LD_ADDR  [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd5};
  localparam logic [11:0] LD_DATA  [8] = '{12'h005, 12'h200, 12'hFFF, 12'h0A0,
                                           12'h300, 12'h010, 12'h020, 12'h123};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [11:0] value, input int budget);
    int n = 0;
    while (prog_ctr !== value && n < budget) begin
      step();
      n++;
    end
    check("wait_pc", prog_ctr, value);
  endtask

  task automatic branch_to(input logic [3:0] idx);
    br_valid = 1'b1; br_taken = 1'b1; lut_idx = idx;
    step();
    br_valid = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    // Reset and idle.
    step(); step();
    check("rst_absjump", absjump_en, 1);
    check("rst_target", target, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_ras_err", ras_err, 0);
    reset = 1'b0;
    repeat (5) step();
    check("idle_pc", prog_ctr, 12'h000);
    check("idle_absjump", absjump_en, 1);
    check("idle_running", running, 0);

    // LUT load; the last write shares its edge with start.
    for (int i = 0; i < 8; i++) begin
      cfg_we = 1'b1; cfg_addr = LD_ADDR[i]; cfg_data = LD_DATA[i];
      start = (i == 7);
      step();
    end
    cfg_we = 1'b0; start = 1'b0;
    check("start_running", running, 1);
    check("start_pc0", prog_ctr, 12'h000);
    check("start_absjump", absjump_en, 0);
    check("start_target", target, 12'h001);
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 12'h777;
    step();
    cfg_we = 1'b0;
    check("first_inc", prog_ctr, 12'h001);

    // Taken branch at 0x005, then a not-taken one.
    wait_pc(12'h005, 20);
    br_valid = 1'b1; br_taken = 1'b1; lut_idx = 4'd3;
    #1;
    check("br_target", target, 12'h0A0);
    step();
    br_valid = 1'b0; br_taken = 1'b0;
    check("br_taken_pc", prog_ctr, 12'h0A0);
    step();
    check("br_after_pc", prog_ctr, 12'h0A1);
    branch_to(4'd0);
    check("br_back_pc", prog_ctr, 12'h005);
    br_valid = 1'b1; br_taken = 1'b0; lut_idx = 4'd3;
    #1;
    check("br_nt_absjump", absjump_en, 0);
    step();
    br_valid = 1'b0;
    check("br_nt_pc", prog_ctr, 12'h006);

    // Stall outranks a taken branch.
    branch_to(4'd6);
    check("stall_entry", prog_ctr, 12'h010);
    stall = 1'b1; br_valid = 1'b1; br_taken = 1'b1; lut_idx = 4'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", prog_ctr, 12'h010);
    end
    stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    step();
    check("stall_resume", prog_ctr, 12'h011);

    // Call at 0x020, return after two increments.
    branch_to(4'd7);
    check("call_entry", prog_ctr, 12'h020);
    call_valid = 1'b1; lut_idx = 4'd1;
    step();
    call_valid = 1'b0;
    check("call_pc", prog_ctr, 12'h200);
    step(); step();
    check("call_inc", prog_ctr, 12'h202);
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    check("ret_pc", prog_ctr, EXP_RET1);

    // Five nested calls overflow a four-deep stack, then five returns.
    for (int i = 0; i < 5; i++) begin
      call_valid = 1'b1; lut_idx = CALL_IDX[i];
      step();
      check("nest_call_pc", prog_ctr, CALL_PC[i]);
      if (i == 3) check("nest_no_err", ras_err, 0);
    end
    call_valid = 1'b0;
    check("nest_ovf_err", ras_err, EXP_OVF_ERR);
    for (int i = 0; i < 5; i++) begin
      ret_valid = 1'b1;
      step();
      check("nest_ret_pc", prog_ctr, EXP_RETS[i]);
    end
    call_valid = 1'b1; lut_idx = 4'd1;
    step();
    ret_valid = 1'b0; call_valid = 1'b0;
    check("ret_call_combo", prog_ctr, EXP_COMBO);

    // Wrap from 0xFFF, then halt at 0x003.
    branch_to(4'd2);
    check("wrap_entry", prog_ctr, 12'hFFF);
    step();
    check("wrap_pc", prog_ctr, 12'h000);
    wait_pc(12'h003, 10);
    halt_req = 1'b1;
    #1;
    check("halt_absjump", absjump_en, 1);
    check("halt_target", target, 12'h003);
    step();
    halt_req = 1'b0;
    check("halt_done", done, 1);
    check("halt_running", running, 0);
    start = 1'b1; br_valid = 1'b1; br_taken = 1'b1; lut_idx = 4'd3;
    for (int i = 0; i < 20; i++) begin
      step();
      check("halt_frozen", prog_ctr, 12'h003);
    end
    check("halt_stays", done, 1);
    start = 1'b0; br_valid = 1'b0; br_taken = 1'b0;

    // Asynchronous reset while running, with a pending return address.
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("rr_pc", prog_ctr, 12'h002);
    call_valid = 1'b1; lut_idx = 4'd1;
    step();
    call_valid = 1'b0;
    check("rr_call", prog_ctr, 12'h200);
    #2;
    reset = 1'b1;
    #1;
    check("rr_absjump", absjump_en, 1);
    check("rr_target", target, 0);
    check("rr_running", running, 0);
    check("rr_done", done, 0);
    check("rr_ras_err", ras_err, 0);
    #1;
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    ret_valid = 1'b1;
    #1;
    check("rr_ret_empty", absjump_en, 0);
    step();
    ret_valid = 1'b0;
    check("rr_ret_pc", prog_ctr, 12'h001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control block that sequences the program counter (PC) by driving its absolute-jump port. It generates `absjump_en`/`target` from start, halt, stall, branch, call and return requests. Branch targets come from an internal lookup table (LUT) of jump addresses loaded before run. It sits between the decode/control logic and the PC. Stalls and halts are realised as a jump-to-self, so the PC itself needs no enable.

## Interface
Parameters:
- `D`, 12, PC width; must match the PC instance.
- `L`, 4, LUT index width; the LUT has 2^L entries of D bits.
- `RD`, 4, return-address-stack depth; used only when the macro in Configuration is defined.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  leave IDLE and begin execution.
- `halt_req`  input  1  stop execution permanently until reset.
- `stall`  input  1  freeze the PC for this cycle.
- `br_valid`  input  1  a conditional branch is present this cycle.
- `br_taken`  input  1  condition result; qualified by `br_valid`.
- `call_valid`  input  1  a subroutine call is present this cycle.
- `ret_valid`  input  1  a subroutine return is present this cycle.
- `lut_idx`  input  L  LUT entry selected by branch/call.
- `cfg_we`  input  1  LUT write strobe.
- `cfg_addr`  input  L  LUT write address.
- `cfg_data`  input  D  LUT write data.
- `prog_ctr`  input  D  current PC value, fed back from the PC.
- `absjump_en`  output  1  to the PC: load `target` on the next edge.
- `target`  output  D  to the PC: next PC value when `absjump_en`=1.
- `running`  output  1  state is RUN.
- `done`  output  1  state is HALT.
- `ras_err`  output  1  sticky flag: RAS overflow or underflow.

## Operation
- States: IDLE, RUN, HALT.
  - IDLE → RUN on `start`.
  - RUN → HALT on `halt_req`.
  - HALT → IDLE only via `reset`.
  - `start` in RUN/HALT and `halt_req` in IDLE are ignored.
- IDLE: `absjump_en`=1, `target`=0 (PC pinned to 0).
  - LUT writes are accepted only in IDLE: `cfg_we` writes `cfg_data` to `lut[cfg_addr]` on the edge.
  - `cfg_we` in RUN/HALT is ignored.
- RUN: request priority is halt > stall > ret > call > branch. Only the highest-priority request acts; all lower ones are dropped.
  - `halt_req`: `absjump_en`=1, `target`=`prog_ctr`.
  - `stall`: `absjump_en`=1, `target`=`prog_ctr`; no other state changes.
  - `ret_valid`: pop; `absjump_en`=1, `target`=popped address.
  - `call_valid`: push `prog_ctr`+1 (mod 2^D); `absjump_en`=1, `target`=`lut[lut_idx]`.
  - `br_valid`&`br_taken`: `absjump_en`=1, `target`=`lut[lut_idx]`.
  - `br_valid`&!`br_taken`, or no request: `absjump_en`=0, so the PC increments.
- HALT: `absjump_en`=1, `target`=`prog_ctr` (PC frozen).
- `target` is don't-care when `absjump_en`=0, but is driven to `prog_ctr`+1 so it is deterministic.
- LUT contents are not reset. Read-before-write is undefined only for unwritten entries.

## Timing
- `absjump_en`/`target` are combinational from the current state and inputs.
  - A request sampled in cycle n is reflected in `prog_ctr` after the edge ending cycle n.
- `running`, `done` and `ras_err` are registered.
- Reset values:
  - state IDLE, `absjump_en`=1, `target`=0.
  - `running`=0, `done`=0, `ras_err`=0.
  - RAS empty (pointer 0, count 0).
- Reset asserted mid-RUN immediately forces IDLE outputs (asynchronous) and clears the RAS.
- Start latency: `start` high in cycle n → `running`=1 in cycle n+1. The first increment happens at the edge ending cycle n+1; the PC stays at 0 through that cycle.
- Halt: `halt_req` in cycle n → `done`=1 from n+1. `prog_ctr` never changes again.
- Simultaneous `cfg_we` and `start` in IDLE: the write completes and the state moves to RUN on the same edge.

## Configuration
- `PC_SEQUENCER_RAS_EN` defined:
  - RD-entry return-address stack is present.
  - Push when full overwrites the oldest entry (circular); the count saturates at RD; `ras_err` is set.
  - Pop when empty: no jump, treated as no request (PC increments); `ras_err` is set.
- Undefined:
  - No stack storage.
  - `call_valid` acts as an unconditional jump to `lut[lut_idx]` with no push.
  - `ret_valid` is ignored; the next-lower request is evaluated instead.
  - `ras_err` is tied to 0.

## Test plan
- Reset then idle: hold `reset` for 2 cycles, release, wait 5 cycles with no `start` → `prog_ctr` stays 0x000, `absjump_en`=1, `running`=0.
- Load and branch:
  - In IDLE, write `lut[3]`=0x0A0, then pulse `start`.
  - When `prog_ctr`=0x005, pulse `br_valid`=`br_taken`=1 with `lut_idx`=3 → next `prog_ctr`=0x0A0, then 0x0A1.
  - Repeat with `br_taken`=0 → `prog_ctr` goes 0x005 → 0x006.
- Stall and priority: in RUN at `prog_ctr`=0x010, hold `stall` for 3 cycles together with `br_taken` → PC holds 0x010 for 3 cycles, then resumes 0x011; the branch is dropped.
- Call/return (macro on):
  - `lut[1]`=0x200. Call at 0x020 → PC 0x200. After 2 increments, `ret_valid` → PC 0x021.
  - 5 nested calls with RD=4 → `ras_err`=1. Five returns leave the 5th return as a no-op.
- Halt and wrap:
  - Jump to `lut`=0xFFF, let it increment → PC wraps to 0x000.
  - Assert `halt_req` at 0x003 → `done`=1, PC frozen at 0x003 for 20 cycles; `start` is ignored.
- Reset mid-run: assert `reset` asynchronously between edges while in RUN → `absjump_en`=1, `target`=0 immediately, and `running`=0 at once.
